// File: rtl/noc_perf_alert_controller.sv
// Alert controller downstream of the NoC performance monitor: periodic sampling, per-type
// debounce, level interrupt with metric snapshot, throttle request and post-ack cooldown.
module noc_perf_alert_controller #(
    parameter int unsigned SAMPLE_PERIOD = 1024,
    parameter int unsigned DEBOUNCE      = 3,
    parameter int unsigned COOLDOWN      = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        performance_degradation,
    input  logic        fairness_alert,
    input  logic        congestion_alert,
    input  logic [7:0]  network_efficiency,
    input  logic [7:0]  jain_fairness_index,
    input  logic [7:0]  congestion_severity,
    input  logic [3:0]  worst_congested_router,
    input  logic [31:0] total_throughput,
    input  logic        irq_ack,
    output logic        irq,
    output logic [2:0]  alert_status,
    output logic [15:0] alert_count,
    output logic [7:0]  snap_efficiency,
    output logic [7:0]  snap_fairness,
    output logic [7:0]  snap_severity,
    output logic [3:0]  snap_worst_router,
    output logic [31:0] snap_throughput,
    output logic        throttle_req,
    output logic [1:0]  ctrl_state
);

    localparam int unsigned SCW = (SAMPLE_PERIOD > 2) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int unsigned CDW = $clog2(COOLDOWN + 1);
    localparam logic [SCW-1:0] SampleLast = SCW'(SAMPLE_PERIOD - 1);
    localparam logic [3:0]     DebMax     = 4'(DEBOUNCE);
    localparam logic [CDW-1:0] CoolInit   = CDW'(COOLDOWN);

    if (SAMPLE_PERIOD < 2) begin : g_bad_period
        $error("SAMPLE_PERIOD must be at least 2");
    end
    if (DEBOUNCE < 1 || DEBOUNCE > 15) begin : g_bad_debounce
        $error("DEBOUNCE must be in 1..15");
    end
    if (COOLDOWN < 1) begin : g_bad_cooldown
        $error("COOLDOWN must be at least 1");
    end

    typedef enum logic [1:0] {
        StMonitor  = 2'b00,
        StAlert    = 2'b01,
        StCooldown = 2'b10
    } state_e;

    state_e          state_q, state_d;
    logic [SCW-1:0]  sample_cnt_q, sample_cnt_d;
    logic [2:0][3:0] deb_q, deb_d;
    logic [CDW-1:0]  cool_q, cool_d;
    logic            irq_q, irq_d;
    logic [2:0]      status_q, status_d;
    logic [15:0]     count_q, count_d;
    logic [7:0]      snap_eff_q, snap_eff_d;
    logic [7:0]      snap_fair_q, snap_fair_d;
    logic [7:0]      snap_sev_q, snap_sev_d;
    logic [3:0]      snap_router_q, snap_router_d;
    logic [31:0]     snap_thr_q, snap_thr_d;
    logic            throttle_q, throttle_d;

    logic            sample_strobe;
    logic [2:0]      flags;
    logic [2:0]      confirm_mask;

    assign sample_strobe = (sample_cnt_q == SampleLast);
    assign flags = {congestion_alert, fairness_alert, performance_degradation};

    always_comb begin
        sample_cnt_d = sample_strobe ? '0 : sample_cnt_q + SCW'(1);
    end

    // Saturating counters; confirmation uses the next value so it lands in the strobe cycle.
    always_comb begin
        deb_d        = deb_q;
        confirm_mask = 3'b000;
        for (int i = 0; i < 3; i++) begin
            if (sample_strobe) begin
                if (flags[i]) begin
                    deb_d[i] = (deb_q[i] >= DebMax) ? DebMax : deb_q[i] + 4'd1;
                end else begin
                    deb_d[i] = 4'd0;
                end
                confirm_mask[i] = flags[i] && (deb_d[i] == DebMax);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        cool_d        = cool_q;
        irq_d         = irq_q;
        status_d      = status_q;
        count_d       = count_q;
        snap_eff_d    = snap_eff_q;
        snap_fair_d   = snap_fair_q;
        snap_sev_d    = snap_sev_q;
        snap_router_d = snap_router_q;
        snap_thr_d    = snap_thr_q;
        throttle_d    = throttle_q;

        unique case (state_q)
            StMonitor: begin
                if (confirm_mask != 3'b000) begin
                    state_d       = StAlert;
                    irq_d         = 1'b1;
                    status_d      = confirm_mask;
                    count_d       = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
                    snap_eff_d    = network_efficiency;
                    snap_fair_d   = jain_fairness_index;
                    snap_sev_d    = congestion_severity;
                    snap_router_d = worst_congested_router;
                    snap_thr_d    = total_throughput;
                    throttle_d    = throttle_q | confirm_mask[2];
                end
            end
            StAlert: begin
                // Acknowledge takes priority over a coincident confirmation.
                if (irq_ack) begin
                    state_d  = StCooldown;
                    irq_d    = 1'b0;
                    status_d = 3'b000;
                    cool_d   = CoolInit;
                end else begin
                    status_d   = status_q | confirm_mask;
                    throttle_d = throttle_q | confirm_mask[2];
                end
            end
            StCooldown: begin
                cool_d = cool_q - CDW'(1);
                if (cool_q == CDW'(1)) begin
                    state_d    = StMonitor;
                    throttle_d = 1'b0;
                end
            end
            default: begin
                state_d = StMonitor;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StMonitor;
            sample_cnt_q  <= '0;
            deb_q         <= '0;
            cool_q        <= '0;
            irq_q         <= 1'b0;
            status_q      <= 3'b000;
            count_q       <= 16'd0;
            snap_eff_q    <= 8'd0;
            snap_fair_q   <= 8'd0;
            snap_sev_q    <= 8'd0;
            snap_router_q <= 4'd0;
            snap_thr_q    <= 32'd0;
            throttle_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            sample_cnt_q  <= sample_cnt_d;
            deb_q         <= deb_d;
            cool_q        <= cool_d;
            irq_q         <= irq_d;
            status_q      <= status_d;
            count_q       <= count_d;
            snap_eff_q    <= snap_eff_d;
            snap_fair_q   <= snap_fair_d;
            snap_sev_q    <= snap_sev_d;
            snap_router_q <= snap_router_d;
            snap_thr_q    <= snap_thr_d;
            throttle_q    <= throttle_d;
        end
    end

    assign irq               = irq_q;
    assign alert_status      = status_q;
    assign alert_count       = count_q;
    assign snap_efficiency   = snap_eff_q;
    assign snap_fairness     = snap_fair_q;
    assign snap_severity     = snap_sev_q;
    assign snap_worst_router = snap_router_q;
    assign snap_throughput   = snap_thr_q;
    assign throttle_req      = throttle_q;
    assign ctrl_state        = state_q;

endmodule

// File: tb/tb_noc_perf_alert_controller.sv
// Directed bench for noc_perf_alert_controller with SAMPLE_PERIOD=8, DEBOUNCE=3, COOLDOWN=20.
// cyc counts clock cycles since reset release; outputs are sampled on the falling edge.
module tb_noc_perf_alert_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        performance_degradation, fairness_alert, congestion_alert;
    logic [7:0]  network_efficiency, jain_fairness_index, congestion_severity;
    logic [3:0]  worst_congested_router;
    logic [31:0] total_throughput;
    logic        irq_ack;
    logic        irq;
    logic [2:0]  alert_status;
    logic [15:0] alert_count;
    logic [7:0]  snap_efficiency, snap_fairness, snap_severity;
    logic [3:0]  snap_worst_router;
    logic [31:0] snap_throughput;
    logic        throttle_req;
    logic [1:0]  ctrl_state;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    noc_perf_alert_controller #(
        .SAMPLE_PERIOD(8),
        .DEBOUNCE     (3),
        .COOLDOWN     (20)
    ) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .performance_degradation(performance_degradation),
        .fairness_alert         (fairness_alert),
        .congestion_alert       (congestion_alert),
        .network_efficiency     (network_efficiency),
        .jain_fairness_index    (jain_fairness_index),
        .congestion_severity    (congestion_severity),
        .worst_congested_router (worst_congested_router),
        .total_throughput       (total_throughput),
        .irq_ack                (irq_ack),
        .irq                    (irq),
        .alert_status           (alert_status),
        .alert_count            (alert_count),
        .snap_efficiency        (snap_efficiency),
        .snap_fairness          (snap_fairness),
        .snap_severity          (snap_severity),
        .snap_worst_router      (snap_worst_router),
        .snap_throughput        (snap_throughput),
        .throttle_req           (throttle_req),
        .ctrl_state             (ctrl_state)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic goto(input int target);
        tick(target - cyc);
    endtask

    task automatic set_metrics(input logic [7:0] e, input logic [7:0] f, input logic [7:0] s,
                               input logic [3:0] r, input logic [31:0] t);
        network_efficiency     = e;
        jain_fairness_index    = f;
        congestion_severity    = s;
        worst_congested_router = r;
        total_throughput       = t;
    endtask

    task automatic do_reset();
        rst_n                   = 1'b0;
        performance_degradation = 1'b0;
        fairness_alert          = 1'b0;
        congestion_alert        = 1'b0;
        irq_ack                 = 1'b0;
        set_metrics(8'd0, 8'd0, 8'd0, 4'd0, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        do_reset();
        n_checks++;
        if ({irq, alert_status, alert_count, throttle_req, ctrl_state} !== 23'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got irq=%b st=%b cnt=%h thr=%b state=%b, want all 0",
                     irq, alert_status, alert_count, throttle_req, ctrl_state);
        end
        n_checks++;
        if ({snap_efficiency, snap_fairness, snap_severity, snap_worst_router,
             snap_throughput} !== 60'd0) begin
            n_fail++;
            $display("FAIL reset_snap: got %h %h %h %h %h, want all 0", snap_efficiency,
                     snap_fairness, snap_severity, snap_worst_router, snap_throughput);
        end
    endtask

    // Congestion confirmed at strobe cycle 23, visible in cycle 24; then ack and cooldown.
    task automatic test_congestion_and_ack();
        do_reset();
        congestion_alert = 1'b1;
        set_metrics(8'd70, 8'd60, 8'd85, 4'd9, 32'd1234);
        goto(23);
        n_checks++;
        if (irq !== 1'b0 || ctrl_state !== 2'b00) begin
            n_fail++;
            $display("FAIL cong_early: got irq=%b state=%b, want 0 00", irq, ctrl_state);
        end
        goto(24);
        n_checks++;
        if (irq !== 1'b1 || ctrl_state !== 2'b01 || alert_status !== 3'b100) begin
            n_fail++;
            $display("FAIL cong_alert: got irq=%b state=%b st=%b, want 1 01 100",
                     irq, ctrl_state, alert_status);
        end
        n_checks++;
        if (snap_severity !== 8'd85 || snap_worst_router !== 4'd9 ||
            snap_efficiency !== 8'd70 || snap_fairness !== 8'd60 ||
            snap_throughput !== 32'd1234) begin
            n_fail++;
            $display("FAIL cong_snap: got sev=%0d rtr=%0d eff=%0d fair=%0d thr=%0d, want 85 9 70 60 1234",
                     snap_severity, snap_worst_router, snap_efficiency, snap_fairness,
                     snap_throughput);
        end
        n_checks++;
        if (throttle_req !== 1'b1 || alert_count !== 16'd1) begin
            n_fail++;
            $display("FAIL cong_thr_cnt: got thr=%b cnt=%0d, want 1 1", throttle_req, alert_count);
        end
        congestion_alert = 1'b0;
        set_metrics(8'd11, 8'd22, 8'd33, 4'd4, 32'd55);
        goto(25);
        irq_ack = 1'b1;
        tick(1);
        irq_ack = 1'b0;
        n_checks++;
        if (irq !== 1'b0 || ctrl_state !== 2'b10 || alert_status !== 3'b000 ||
            throttle_req !== 1'b1) begin
            n_fail++;
            $display("FAIL ack_cool: got irq=%b state=%b st=%b thr=%b, want 0 10 000 1",
                     irq, ctrl_state, alert_status, throttle_req);
        end
        goto(45);
        n_checks++;
        if (ctrl_state !== 2'b10 || throttle_req !== 1'b1) begin
            n_fail++;
            $display("FAIL cool_last: got state=%b thr=%b, want 10 1", ctrl_state, throttle_req);
        end
        goto(46);
        n_checks++;
        if (ctrl_state !== 2'b00 || throttle_req !== 1'b0 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL cool_end: got state=%b thr=%b irq=%b, want 00 0 0",
                     ctrl_state, throttle_req, irq);
        end
        n_checks++;
        if (snap_severity !== 8'd85 || snap_worst_router !== 4'd9 ||
            snap_throughput !== 32'd1234) begin
            n_fail++;
            $display("FAIL snap_hold: got sev=%0d rtr=%0d thr=%0d, want 85 9 1234",
                     snap_severity, snap_worst_router, snap_throughput);
        end
    endtask

    // Two samples high, one low, two high: never reaches three consecutive.
    task automatic test_debounce_gap();
        do_reset();
        fairness_alert = 1'b1;
        goto(16);
        fairness_alert = 1'b0;
        goto(24);
        fairness_alert = 1'b1;
        goto(40);
        fairness_alert = 1'b0;
        goto(48);
        n_checks++;
        if (irq !== 1'b0 || alert_status !== 3'b000 || alert_count !== 16'd0 ||
            ctrl_state !== 2'b00) begin
            n_fail++;
            $display("FAIL deb_gap: got irq=%b st=%b cnt=%0d state=%b, want 0 000 0 00",
                     irq, alert_status, alert_count, ctrl_state);
        end
    endtask

    // Perf alert, then fairness accumulates; then ack coincides with a confirming strobe.
    task automatic test_accumulate_and_coincident_ack();
        do_reset();
        performance_degradation = 1'b1;
        set_metrics(8'd40, 8'd90, 8'd10, 4'd2, 32'd777);
        goto(8);
        fairness_alert = 1'b1;
        goto(24);
        n_checks++;
        if (ctrl_state !== 2'b01 || alert_status !== 3'b001 || throttle_req !== 1'b0 ||
            alert_count !== 16'd1) begin
            n_fail++;
            $display("FAIL perf_alert: got state=%b st=%b thr=%b cnt=%0d, want 01 001 0 1",
                     ctrl_state, alert_status, throttle_req, alert_count);
        end
        set_metrics(8'd41, 8'd50, 8'd12, 4'd3, 32'd888);
        goto(32);
        n_checks++;
        if (alert_status !== 3'b011 || alert_count !== 16'd1 || snap_efficiency !== 8'd40 ||
            snap_throughput !== 32'd777 || ctrl_state !== 2'b01) begin
            n_fail++;
            $display("FAIL accum: got st=%b cnt=%0d eff=%0d thr=%0d state=%b, want 011 1 40 777 01",
                     alert_status, alert_count, snap_efficiency, snap_throughput, ctrl_state);
        end
        goto(39);
        irq_ack = 1'b1;
        tick(1);
        irq_ack = 1'b0;
        n_checks++;
        if (alert_status !== 3'b000 || ctrl_state !== 2'b10 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_coinc: got st=%b state=%b irq=%b, want 000 10 0",
                     alert_status, ctrl_state, irq);
        end
        goto(63);
        n_checks++;
        if (ctrl_state !== 2'b00 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL pre_realert: got state=%b irq=%b, want 00 0", ctrl_state, irq);
        end
        goto(64);
        n_checks++;
        if (irq !== 1'b1 || ctrl_state !== 2'b01 || alert_count !== 16'd2 ||
            alert_status !== 3'b011 || snap_efficiency !== 8'd41) begin
            n_fail++;
            $display("FAIL realert: got irq=%b state=%b cnt=%0d st=%b eff=%0d, want 1 01 2 011 41",
                     irq, ctrl_state, alert_count, alert_status, snap_efficiency);
        end
    endtask

    task automatic test_count_saturate();
        do_reset();
        goto(1);
        force dut.count_q = 16'hFFFF;
        goto(3);
        release dut.count_q;
        congestion_alert = 1'b1;
        goto(24);
        n_checks++;
        if (irq !== 1'b1 || alert_count !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL cnt_sat: got irq=%b cnt=%h, want 1 ffff", irq, alert_count);
        end
    endtask

    task automatic test_reset_mid_cooldown();
        do_reset();
        congestion_alert = 1'b1;
        set_metrics(8'd5, 8'd6, 8'd7, 4'd8, 32'd9);
        goto(25);
        irq_ack = 1'b1;
        tick(1);
        irq_ack = 1'b0;
        goto(30);
        n_checks++;
        if (ctrl_state !== 2'b10 || throttle_req !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre: got state=%b thr=%b, want 10 1", ctrl_state, throttle_req);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({irq, alert_status, alert_count, throttle_req, ctrl_state} !== 23'd0 ||
            {snap_efficiency, snap_fairness, snap_severity, snap_worst_router,
             snap_throughput} !== 60'd0) begin
            n_fail++;
            $display("FAIL rst_mid: got irq=%b st=%b cnt=%h thr=%b state=%b sev=%0d, want all 0",
                     irq, alert_status, alert_count, throttle_req, ctrl_state, snap_severity);
        end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_congestion_and_ack();
        test_debounce_gap();
        test_accumulate_and_coincident_ack();
        test_count_saturate();
        test_reset_mid_cooldown();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
